isqrt_iter_fsm: RTL
===================

// Module: isqrt_iter_fsm
// PURPOSE
//  Multi-cycle integer square root responder serving the isqrt request/response interface.
//  Computes y = floor(sqrt(x)), one result bit per clock, with digit-by-digit binary recurrence.
//  Sits behind the formula FSMs; one instance per isqrt_N_x/isqrt_N_y port pair.
//  x_vld is a single-cycle pulse; no input hold or backpressure is required from the initiator.
// PARAMETERS
//  WIDTH   32   operand width; must be even and >= 4; result width is WIDTH/2
// PORTS
//  clk      in   1          clock
//  rst      in   1          reset, asynchronous, active-high
//  x_vld    in   1          request pulse; x is sampled on the same edge
//  x        in   WIDTH      radicand, unsigned
//  y_vld    out  1          one-cycle result strobe
//  y        out  WIDTH/2    floor(sqrt(x)); holds its value until the next result
//  ready    out  1          1 in ST_IDLE and ST_DONE; a request in that cycle is accepted
//  err_ovr  out  1          only with ISQRT_ITER_OVERRUN_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, immediate):
//   - state = ST_IDLE; y_vld = 0; y = 0; ready = 1; err_ovr = 0.
//   - An in-flight computation is discarded; no y_vld is produced for it.
//  States:
//   - ST_IDLE: x_vld -> ST_RUN; load op = x, rem = 0, root = 0, cnt = 0.
//   - ST_RUN: one iteration per edge; after the iteration with cnt == WIDTH/2-1 -> ST_DONE;
//     y <= final root.
//   - ST_DONE: y_vld = 1 for exactly this cycle. x_vld -> ST_RUN with a fresh load,
//     otherwise -> ST_IDLE.
//  Iteration (unsigned):
//   - rem' = {rem, op[WIDTH-1:WIDTH-2]}
//   - trial = {root, 2'b01}
//   - op <<= 2
//   - if rem' >= trial: rem = rem' - trial, root = {root, 1'b1}
//   - else: rem = rem', root = {root, 1'b0}
//   - Widths: rem is WIDTH/2+2 bits; trial is WIDTH/2+2 bits; root is WIDTH/2 bits.
//     No truncation occurs at WIDTH = 32.
//  Latency: x_vld high in cycle k -> y_vld high in cycle k + WIDTH/2 + 1 (k+17 at WIDTH=32).
//  Back-to-back: x_vld in the ST_DONE cycle is accepted. This supports initiators that issue
//   the next request on the same cycle they consume y_vld. Throughput is one result per
//   WIDTH/2+1 cycles.
//  x_vld in ST_RUN: the request is dropped; the current computation is unaffected.
//  y is registered and changes only on entry to ST_DONE; y_vld is decoded from the state.
//  x = 0 -> y = 0; x = 2**WIDTH-1 -> y = 2**(WIDTH/2)-1; no special-case paths.
// CONFIGURATION
//  ISQRT_ITER_OVERRUN_EN
//   - Defined: adds port err_ovr. err_ovr is sticky; it sets on the edge after any x_vld
//     seen in ST_RUN and clears only on rst.
//   - Undefined: the port and its logic are absent; dropped requests are silent.
// STRUCTURE
//  - isqrt_iter_pkg: typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} isqrt_state_t;
//    localparam for the default WIDTH.
//  - Sub-module isqrt_iter_step (combinational):
//    - in: rem, root, next two op bits
//    - out: rem', root'
//    - Instantiated once; the FSM and counter stay in isqrt_iter_fsm.
//  - Iteration counter is $clog2(WIDTH/2) bits wide.
// TESTING
//  1. Pulse x_vld with x=0, 1, 15, 16, 17 -> y = 0, 1, 3, 4, 4; each y_vld occurs exactly
//     17 cycles after x_vld and lasts 1 cycle.
//  2. x=32'hFFFF_FFFF -> y=16'hFFFF; x=32'hFFFE_0001 -> y=16'hFFFF; x=32'hFFFE_0000 -> y=16'hFFFE.
//  3. x_vld=1 on the ST_DONE cycle of the previous request (x=100 then x=144)
//     -> y=10 then y=12; the second y_vld comes 17 cycles after the first; no bubble.
//  4. Second x_vld 5 cycles into ST_RUN -> only the first result appears; ready=0 at the
//     second pulse. With ISQRT_ITER_OVERRUN_EN, err_ovr = 1 from the next cycle onward.
//  5. Assert rst mid-ST_RUN (x=81) -> y_vld=0, y=0, ready=1 immediately; no later y_vld.
//     A new x=81 yields y=9.
//  6. 10k random x with random gaps -> y*y <= x < (y+1)*(y+1) for every result;
//     y stable between strobes.

Source files
------------

// File: rtl/isqrt_iter_pkg.sv
// Shared types and defaults for the iterative integer square root responder.
// The optional overrun flag is controlled by the ISQRT_ITER_OVERRUN_EN macro in isqrt_iter_fsm.
package isqrt_iter_pkg;

    localparam int ISQRT_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } isqrt_state_t;

endpackage

// File: rtl/isqrt_iter_step.sv
// One digit-by-digit binary square-root step: consumes two radicand bits, yields one root bit.
// Purely combinational; the caller registers rem/root between steps.
module isqrt_iter_step
    import isqrt_iter_pkg::*;
#(
    parameter int WIDTH = ISQRT_WIDTH_DEF
) (
    input  logic [WIDTH/2+1:0] rem_i,
    input  logic [WIDTH/2-1:0] root_i,
    input  logic [1:0]         bits_i,
    output logic [WIDTH/2+1:0] rem_o,
    output logic [WIDTH/2-1:0] root_o
);

    localparam int HW = WIDTH / 2;
    localparam int RW = HW + 2;

    logic [RW-1:0] rem_sh;
    logic [RW-1:0] trial;
    logic          take;

    assign rem_sh = {rem_i[RW-3:0], bits_i};
    assign trial  = {root_i, 2'b01};
    // Compare at full width so the shifted-out remainder bits still take part.
    assign take   = ({rem_i, bits_i} >= {2'b00, trial});

    always_comb begin
        rem_o  = rem_sh;
        root_o = {root_i[HW-2:0], 1'b0};
        if (take) begin
            rem_o  = rem_sh - trial;
            root_o = {root_i[HW-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/isqrt_iter_fsm.sv
// Multi-cycle floor(sqrt(x)) responder, one root bit per clock, IDLE/RUN/DONE control.
// Define ISQRT_ITER_OVERRUN_EN to add the sticky err_ovr flag for requests dropped while busy.
module isqrt_iter_fsm
    import isqrt_iter_pkg::*;
#(
    parameter int WIDTH = ISQRT_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x_vld,
    input  logic [WIDTH-1:0]   x,
    output logic               y_vld,
    output logic [WIDTH/2-1:0] y,
    output logic               ready,
`ifdef ISQRT_ITER_OVERRUN_EN
    output logic               err_ovr,
`endif
    output logic [1:0]         dbg_state
);

    // Handshake: x_vld is a one-cycle pulse accepted whenever ready=1 on that edge
    // (ready is high in IDLE and DONE); y_vld is a one-cycle strobe with no backpressure.

    localparam int HW = WIDTH / 2;
    localparam int RW = HW + 2;
    localparam int CW = (HW > 1) ? $clog2(HW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HW - 1);

    isqrt_state_t   state_q, state_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [RW-1:0]  rem_q, rem_d;
    logic [HW-1:0]  root_q, root_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [HW-1:0]  y_q, y_d;

    logic [RW-1:0]  rem_nx;
    logic [HW-1:0]  root_nx;

    isqrt_iter_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .root_i (root_q),
        .bits_i (op_q[WIDTH-1:WIDTH-2]),
        .rem_o  (rem_nx),
        .root_o (root_nx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rem_d   = rem_q;
        root_d  = root_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (x_vld) begin
                    state_d = ST_RUN;
                    op_d    = x;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                op_d   = op_q << 2;
                rem_d  = rem_nx;
                root_d = root_nx;
                cnt_d  = cnt_q + 1'b1;
                // y only moves on the RUN->DONE edge so it holds between strobes.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    y_d     = root_nx;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef ISQRT_ITER_OVERRUN_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == ST_RUN && x_vld) begin
            err_q <= 1'b1;
        end
    end

    assign err_ovr = err_q;
`endif

    assign y_vld     = (state_q == ST_DONE);
    assign ready     = (state_q != ST_RUN);
    assign y         = y_q;
    assign dbg_state = state_q;

endmodule
